// File: rtl/tog_dec_pkg.sv
// tog_dec_pkg: shared types, defaults and saturating add for toggle_event_decoder
//   buf_state_e : output buffer state (EMPTY / FULL)
//   CNT_W_DEF   : default accumulator / count width
//   sat_add     : returns {overflow, value}, where value is a + inc clamped to max
package tog_dec_pkg;

    typedef enum logic {BUF_EMPTY, BUF_FULL} buf_state_e;

    localparam int CNT_W_DEF = 8;

    function automatic logic [32:0] sat_add(input logic [31:0] a, input logic [31:0] inc, input logic [31:0] max);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, inc};
        return (s > {1'b0, max}) ? {1'b1, max} : {1'b0, s[31:0]};
    endfunction

endpackage

// File: rtl/tog_sync_edge.sv
// tog_sync_edge: synchronises a remote toggle level and flags each level change
//   clk, reset : clock, async active-high reset
//   tog_in     : asynchronous toggle level
//   tog_level  : registered, synchronised level
//   evt        : combinational, high when tog_level will flip at the next edge
// Optional TOG_DEC_GLITCH_FILT_EN: the synchronised level must be stable for
// two cycles before it is accepted, which suppresses single-cycle glitches.
module tog_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic tog_in,
    output logic tog_level,
    output logic evt
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_q;
    logic                   last;

    assign last      = sync_q[SYNC_STAGES-1];
    assign tog_level = level_q;

`ifdef TOG_DEC_GLITCH_FILT_EN
    logic hold_q;

    // last must equal its previous value before it may differ from level_q
    assign evt = (last == hold_q) && (last != level_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) hold_q <= 1'b0;
        else       hold_q <= last;
    end
`else
    assign evt = last ^ level_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], tog_in};
            level_q <= level_q ^ evt;
        end
    end

endmodule

// File: rtl/toggle_event_decoder.sv
// toggle_event_decoder: turns toggle-line level flips into counted events
//   clk, reset : clock, async active-high reset
//   tog_in     : toggle level from the remote T-ff
//   tog_level  : synchronised copy of tog_in
//   pulse_out  : one-cycle pulse per detected toggle
//   cnt_valid / cnt_ready / cnt_data / cnt_ovf : one-entry valid/ready count buffer;
//                cnt_ovf flags a batch that saturated
// Optional TOG_DEC_GLITCH_FILT_EN enables the glitch filter in tog_sync_edge.
module toggle_event_decoder
    import tog_dec_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tog_in,
    output logic             tog_level,
    output logic             pulse_out,
    output logic             cnt_valid,
    input  logic             cnt_ready,
    output logic [CNT_W-1:0] cnt_data,
    output logic             cnt_ovf
);

    localparam logic [31:0] MAX = 32'((64'd1 << CNT_W) - 64'd1);

    buf_state_e       state_q;
    logic [CNT_W-1:0] acc_q, data_q, acc_d;
    logic             sat_q, ovf_q, pulse_q, sat_d;
    logic             evt;

    tog_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .reset     (reset),
        .tog_in    (tog_in),
        .tog_level (tog_level),
        .evt       (evt)
    );

    // acc plus this cycle's event, clamped; the event is never lost between acc and buffer
    assign acc_d = CNT_W'(sat_add(32'(acc_q), 32'(evt), MAX));
    assign sat_d = sat_q | 1'(sat_add(32'(acc_q), 32'(evt), MAX) >> 32);

    assign pulse_out = pulse_q;
    assign cnt_valid = (state_q == BUF_FULL);
    assign cnt_data  = data_q;
    assign cnt_ovf   = ovf_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BUF_EMPTY;
            acc_q   <= '0;
            sat_q   <= 1'b0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= evt;
            // buffer is free to take a batch: empty, or being consumed this edge
            if (state_q == BUF_EMPTY || cnt_ready) begin
                if (acc_d != '0) begin
                    state_q <= BUF_FULL;
                    data_q  <= acc_d;
                    ovf_q   <= sat_d;
                    acc_q   <= '0;
                    sat_q   <= 1'b0;
                end else begin
                    state_q <= BUF_EMPTY;
                end
            end else begin
                acc_q <= acc_d;
                sat_q <= sat_d;
            end
        end
    end

endmodule

// File: tb/tb_toggle_event_decoder.sv
// tb_toggle_event_decoder: directed self-checking bench for toggle_event_decoder
module tb_toggle_event_decoder;

    localparam int CNT_W = 4;
    localparam int SYNC  = 2;
`ifdef TOG_DEC_GLITCH_FILT_EN
    localparam int LAT           = SYNC + 2;
    localparam int GLITCH_PULSES = 0;
`else
    localparam int LAT           = SYNC + 1;
    localparam int GLITCH_PULSES = 2;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             tog_in = 1'b0;
    logic             cnt_ready = 1'b0;
    logic             tog_level, pulse_out, cnt_valid, cnt_ovf;
    logic [CNT_W-1:0] cnt_data;

    int n_cmp = 0;
    int n_bad = 0;
    int n_tog = 0;
    int total = 0;
    int n_pulse = 0;
    int n_valid = 0;
    int v0, p0;

    always #5 clk = ~clk;

    toggle_event_decoder #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC)) dut (
        .clk       (clk),
        .reset     (reset),
        .tog_in    (tog_in),
        .tog_level (tog_level),
        .pulse_out (pulse_out),
        .cnt_valid (cnt_valid),
        .cnt_ready (cnt_ready),
        .cnt_data  (cnt_data),
        .cnt_ovf   (cnt_ovf)
    );

    // pre-edge values are what the DUT acts on at this edge
    always @(posedge clk) begin
        if (pulse_out) n_pulse <= n_pulse + 1;
        if (cnt_valid) n_valid <= n_valid + 1;
        if (cnt_valid && cnt_ready) total <= total + int'(cnt_data);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic flip;
        tog_in = ~tog_in;
        n_tog++;
    endtask

    task automatic take;
        cnt_ready = 1'b1;
        cyc(1);
        cnt_ready = 1'b0;
    endtask

    initial begin
        cyc(3);
        chk("rst_outs", {tog_level, pulse_out, cnt_valid, cnt_ovf, cnt_data}, 0);
        reset = 1'b0;
        v0 = n_valid;
        p0 = n_pulse;
        cyc(20);
        chk("idle_valid", n_valid - v0, 0);
        chk("idle_pulse", n_pulse - p0, 0);

        flip();
        for (int i = 1; i <= LAT + 1; i++) begin
            cyc(1);
            chk($sformatf("single_pulse_e%0d", i), pulse_out, i == LAT);
            chk($sformatf("single_level_e%0d", i), tog_level, i >= LAT);
        end
        chk("single_valid", cnt_valid, 1);
        chk("single_data", cnt_data, 1);
        chk("single_ovf", cnt_ovf, 0);
        take();
        chk("single_clr", cnt_valid, 0);

        flip();
        cyc(4);
        for (int i = 0; i < 4; i++) begin
            flip();
            cyc(4);
            chk($sformatf("burst_hold%0d", i), cnt_data, 1);
        end
        cyc(LAT);
        chk("burst_valid", cnt_valid, 1);
        chk("burst_first", cnt_data, 1);
        cnt_ready = 1'b1;
        cyc(1);
        chk("burst_reload", cnt_data, 4);
        chk("burst_reload_v", cnt_valid, 1);
        cyc(1);
        cnt_ready = 1'b0;
        chk("burst_drain", cnt_valid, 0);

        flip();
        cyc(LAT + 1);
        flip();
        cyc(LAT + 1);
        flip();
        cyc(LAT - 1);
        take();
        chk("sim_pulse", pulse_out, 1);
        chk("sim_valid", cnt_valid, 1);
        chk("sim_data", cnt_data, 2);
        take();
        chk("sim_drain", cnt_valid, 0);
        chk("sb_total", total, n_tog);

        flip();
        cyc(LAT + 1);
        chk("sat_first", cnt_data, 1);
        repeat (20) begin
            flip();
            cyc(3);
        end
        cyc(LAT);
        chk("sat_pre_data", cnt_data, 1);
        chk("sat_pre_ovf", cnt_ovf, 0);
        take();
        chk("sat_data", cnt_data, 15);
        chk("sat_ovf", cnt_ovf, 1);
        flip();
        cyc(3);
        flip();
        cyc(LAT + 1);
        chk("sat_stable", cnt_data, 15);
        take();
        chk("sat_next_data", cnt_data, 2);
        chk("sat_next_ovf", cnt_ovf, 0);
        take();
        chk("sat_drain", cnt_valid, 0);

        cnt_ready = 1'b1;
        p0 = n_pulse;
        flip();
        cyc(1);
        flip();
        cyc(LAT + 4);
        cnt_ready = 1'b0;
        chk("glitch_pulses", n_pulse - p0, GLITCH_PULSES);
        chk("glitch_valid", cnt_valid, 0);

        flip();
        for (int i = 1; i <= LAT + 1; i++) begin
            cyc(1);
            chk($sformatf("hold_pulse_e%0d", i), pulse_out, i == LAT);
        end

        for (int i = 0; i < 3; i++) begin
            flip();
            cyc(3);
        end
        cyc(LAT);
        chk("mid_valid", cnt_valid, 1);
        chk("mid_data", cnt_data, 1);
        #2;
        reset = 1'b1;
        tog_in = 1'b0;
        #1;
        chk("mid_async_clr", {tog_level, pulse_out, cnt_valid, cnt_ovf, cnt_data}, 0);
        cyc(2);
        reset = 1'b0;
        v0 = n_valid;
        p0 = n_pulse;
        cyc(20);
        chk("mid_no_valid", n_valid - v0, 0);
        chk("mid_no_pulse", n_pulse - p0, 0);

        reset = 1'b1;
        tog_in = 1'b1;
        cyc(2);
        reset = 1'b0;
        p0 = n_pulse;
        cyc(LAT + 4);
        chk("rel_high_pulses", n_pulse - p0, 1);
        chk("rel_high_valid", cnt_valid, 1);
        chk("rel_high_data", cnt_data, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
